// File: rtl/jt10_adpcma_sched.sv
// -----------------------------------------------------------------------------
// jt10_adpcma_sched
//   Register front-end and slot scheduler for the six-channel ADPCM-A address
//   counter. CPU writes leave start/end address updates and key-on/off requests
//   pending per channel. Each request is issued on the counter's shared update
//   port when the rotating slot reaches that channel.
//
// Ports
//   rst_n      async active-low reset
//   clk        single clock
//   cen        clock enable shared with the address counter
//   cpu_wr     one-cycle write strobe (not gated by cen)
//   cpu_addr   register address
//   cpu_din    register data
//   slot       channel currently presented to the counter (0..5)
//   addr_in    {bank[3:0], addr[11:0]} for the counter, 0 when idle
//   up_start   load start address for channel `slot`
//   up_end     load end address for channel `slot`
//   aon/aoff   key on/off for channel `slot`
//   clr_flags  one-clk flag clear pulse to the counter
//   pending    per-channel OR of all outstanding requests
//
// Optional feature: define JT10_ADPCMA_KEYCLR_EN so that every aon issue also
//   pulses the matching clr_flags bit on the same cen edge.
// -----------------------------------------------------------------------------
module jt10_adpcma_sched (
  input  logic        rst_n,
  input  logic        clk,
  input  logic        cen,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [2:0]  slot,
  output logic [15:0] addr_in,
  output logic        up_start,
  output logic        up_end,
  output logic        aon,
  output logic        aoff,
  output logic [5:0]  clr_flags,
  output logic [5:0]  pending
);

  // Latched address bytes per channel
  logic [7:0] start_lo [0:5];
  logic [7:0] start_hi [0:5];
  logic [7:0] end_lo   [0:5];
  logic [7:0] end_hi   [0:5];

  logic [5:0] start_pend, end_pend, aon_pend, aoff_pend;
  logic [5:0] start_pend_nxt, end_pend_nxt, aon_pend_nxt, aoff_pend_nxt;
  logic [5:0] clr_nxt;
  logic [2:0] s_next;
  logic [2:0] ch;
  logic       ch_ok;
  logic       wr_key, wr_clr, wr_slo, wr_shi, wr_elo, wr_ehi;
  logic       iss_start, iss_end, iss_aon, iss_aoff;
  logic [15:0] iss_addr;

  assign pending = start_pend | end_pend | aon_pend | aoff_pend;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    s_next = (slot == 3'd5) ? 3'd0 : slot + 3'd1;
    ch     = cpu_addr[2:0];
    ch_ok  = (ch <= 3'd5);
    wr_key = cpu_wr && (cpu_addr == 8'h00);
    wr_clr = cpu_wr && (cpu_addr == 8'h01);
    wr_slo = cpu_wr && ch_ok && (cpu_addr[7:3] == 5'b00010);
    wr_shi = cpu_wr && ch_ok && (cpu_addr[7:3] == 5'b00011);
    wr_elo = cpu_wr && ch_ok && (cpu_addr[7:3] == 5'b00100);
    wr_ehi = cpu_wr && ch_ok && (cpu_addr[7:3] == 5'b00101);

    // Issue decision for the slot the next cen edge will present.
    // Start has priority; a pending end waits for the following visit.
    iss_start = start_pend[s_next];
    iss_end   = !start_pend[s_next] && end_pend[s_next];
    iss_aon   = aon_pend[s_next];
    iss_aoff  = !aon_pend[s_next] && aoff_pend[s_next];
    iss_addr  = 16'h0000;
    if (iss_start)    iss_addr = {start_hi[s_next], start_lo[s_next]};
    else if (iss_end) iss_addr = {end_hi[s_next], end_lo[s_next]};

    start_pend_nxt = start_pend;
    end_pend_nxt   = end_pend;
    aon_pend_nxt   = aon_pend;
    aoff_pend_nxt  = aoff_pend;

    // Clears from issuing come first so a same-edge CPU write overrides them.
    if (cen) begin
      if (iss_start) start_pend_nxt[s_next] = 1'b0;
      if (iss_end)   end_pend_nxt[s_next]   = 1'b0;
      if (iss_aon)   aon_pend_nxt[s_next]   = 1'b0;
      if (iss_aoff)  aoff_pend_nxt[s_next]  = 1'b0;
    end

    if (wr_shi) start_pend_nxt[ch] = 1'b1;
    if (wr_ehi) end_pend_nxt[ch]   = 1'b1;
    if (wr_key) begin
      if (cpu_din[7]) begin
        aoff_pend_nxt = aoff_pend_nxt |  cpu_din[5:0];
        aon_pend_nxt  = aon_pend_nxt  & ~cpu_din[5:0];
      end else begin
        aon_pend_nxt  = aon_pend_nxt  |  cpu_din[5:0];
        aoff_pend_nxt = aoff_pend_nxt & ~cpu_din[5:0];
      end
    end

    clr_nxt = wr_clr ? cpu_din[5:0] : 6'd0;
`ifdef JT10_ADPCMA_KEYCLR_EN
    if (cen && iss_aon) clr_nxt[s_next] = 1'b1;
`else
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so all reads in
  // this block see pre-edge values (a same-edge write never leaks into an issue).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot       <= 3'd0;
      addr_in    <= 16'h0000;
      up_start   <= 1'b0;
      up_end     <= 1'b0;
      aon        <= 1'b0;
      aoff       <= 1'b0;
      clr_flags  <= 6'd0;
      start_pend <= 6'd0;
      end_pend   <= 6'd0;
      aon_pend   <= 6'd0;
      aoff_pend  <= 6'd0;
      // NOTE: the byte latches are small register files that must read back 0
      // after reset, so they are reset explicitly rather than left as RAM.
      for (int i = 0; i < 6; i++) begin
        start_lo[i] <= 8'h00;
        start_hi[i] <= 8'h00;
        end_lo[i]   <= 8'h00;
        end_hi[i]   <= 8'h00;
      end
    end else begin
      start_pend <= start_pend_nxt;
      end_pend   <= end_pend_nxt;
      aon_pend   <= aon_pend_nxt;
      aoff_pend  <= aoff_pend_nxt;
      clr_flags  <= clr_nxt;

      if (wr_slo) start_lo[ch] <= cpu_din;
      if (wr_shi) start_hi[ch] <= cpu_din;
      if (wr_elo) end_lo[ch]   <= cpu_din;
      if (wr_ehi) end_hi[ch]   <= cpu_din;

      if (cen) begin
        slot     <= s_next;
        up_start <= iss_start;
        up_end   <= iss_end;
        aon      <= iss_aon;
        aoff     <= iss_aoff;
        addr_in  <= iss_addr;
      end
    end
  end

endmodule

// File: tb/tb_jt10_adpcma_sched.sv
// -----------------------------------------------------------------------------
// tb_jt10_adpcma_sched
//   Directed bench for jt10_adpcma_sched. Each scenario starts from reset with
//   cen low so the slot position is known (slot 0), performs its writes, then
//   raises cen and steps edge by edge against hand-computed expectations.
//   Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_jt10_adpcma_sched;

  logic        rst_n, clk, cen, cpu_wr;
  logic [7:0]  cpu_addr, cpu_din;
  logic [2:0]  slot;
  logic [15:0] addr_in;
  logic        up_start, up_end, aon, aoff;
  logic [5:0]  clr_flags, pending;

  int n_checks = 0;
  int n_errors = 0;

  // Strobe encodings as {up_start, up_end, aon, aoff}
  localparam logic [3:0] S_NONE  = 4'b0000;
  localparam logic [3:0] S_START = 4'b1000;
  localparam logic [3:0] S_END   = 4'b0100;
  localparam logic [3:0] S_AON   = 4'b0010;
  localparam logic [3:0] S_AOFF  = 4'b0001;

`ifdef JT10_ADPCMA_KEYCLR_EN
  localparam logic [5:0] KEYCLR_CH3 = 6'h08;
`else
  localparam logic [5:0] KEYCLR_CH3 = 6'h00;
`endif

  jt10_adpcma_sched dut (
    .rst_n     (rst_n),
    .clk       (clk),
    .cen       (cen),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .slot      (slot),
    .addr_in   (addr_in),
    .up_start  (up_start),
    .up_end    (up_end),
    .aon       (aon),
    .aoff      (aoff),
    .clr_flags (clr_flags),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the write lands on the next rising edge.
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cpu_wr   = 1'b1;
    cpu_addr = a;
    cpu_din  = d;
    @(negedge clk);
    cpu_wr   = 1'b0;
  endtask

  // Reset with cen low; ends at a falling edge with slot 0.
  task automatic do_reset();
    cen   = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Advance one clock and compare slot, strobes and addr_in.
  task automatic tick_expect(input string tag, input logic [2:0] exp_slot,
                             input logic [3:0] exp_strb, input logic [15:0] exp_addr);
    @(negedge clk);
    check({tag, " slot"}, slot, exp_slot);
    check({tag, " strobes"}, {up_start, up_end, aon, aoff}, exp_strb);
    check({tag, " addr_in"}, addr_in, exp_addr);
  endtask

  initial begin
    cpu_wr   = 1'b0;
    cpu_addr = 8'h00;
    cpu_din  = 8'h00;
    cen      = 1'b1;
    rst_n    = 1'b0;

    // ---- Reset state and free-running rotation ----
    #12;
    check("rst slot", slot, 3'd0);
    check("rst pending", pending, 6'd0);
    check("rst clr_flags", clr_flags, 6'd0);
    check("rst addr_in", addr_in, 16'h0);
    check("rst strobes", {up_start, up_end, aon, aoff}, S_NONE);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++)
      tick_expect("rotate", 3'(i % 6), S_NONE, 16'h0);

    // Mid-rotation asynchronous reset clears slot and pending at once
    wr(8'h1B, 8'h00);
    check("pre-rst pending", pending, 6'h08);
    check("pre-rst slot", slot, 3'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst slot", slot, 3'd0);
    check("async rst pending", pending, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- Channel 2 start; high byte rewritten while pending ----
    do_reset();
    wr(8'h12, 8'h34);
    wr(8'h1A, 8'h11);
    wr(8'h1A, 8'h5C);
    check("ch2 pending", pending, 6'h04);
    cen = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick_expect("ch2", 3'(i % 6), (i == 2) ? S_START : S_NONE,
                  (i == 2) ? 16'h5C34 : 16'h0);
      if (i == 2) check("ch2 pending after issue", pending, 6'h00);
    end

    // ---- Channel 4 start then end; cen low holds everything ----
    do_reset();
    wr(8'h14, 8'hAA);
    wr(8'h1C, 8'h11);
    wr(8'h24, 8'hBB);
    wr(8'h2C, 8'h22);
    for (int i = 0; i < 4; i++) tick_expect("cen low", 3'd0, S_NONE, 16'h0);
    check("ch4 pending", pending, 6'h10);
    cen = 1'b1;
    for (int i = 1; i <= 11; i++)
      tick_expect("ch4", 3'(i % 6),
                  (i == 4) ? S_START : (i == 10) ? S_END : S_NONE,
                  (i == 4) ? 16'h11AA : (i == 10) ? 16'h22BB : 16'h0);
    check("ch4 pending done", pending, 6'h00);

    // ---- Key on 0 and 5, then key off 0 before slot 0 ----
    do_reset();
    wr(8'h00, 8'h21);
    check("key pending on", pending, 6'h21);
    wr(8'h00, 8'h81);
    check("key pending off", pending, 6'h21);
    cen = 1'b1;
    for (int i = 1; i <= 7; i++)
      tick_expect("key", 3'(i % 6),
                  (i == 5) ? S_AON : (i == 6) ? S_AOFF : S_NONE, 16'h0);
    check("key pending done", pending, 6'h00);

    // ---- Flag clear pulse ----
    wr(8'h01, 8'h3F);
    check("clr pulse", clr_flags, 6'h3F);
    @(negedge clk);
    check("clr pulse end", clr_flags, 6'h00);

    // ---- Key-on channel 3 (flag clear only with the optional feature) ----
    do_reset();
    wr(8'h00, 8'h08);
    cen = 1'b1;
    tick_expect("kc3", 3'd1, S_NONE, 16'h0);
    tick_expect("kc3", 3'd2, S_NONE, 16'h0);
    tick_expect("kc3", 3'd3, S_AON, 16'h0);
    check("kc3 clr", clr_flags, KEYCLR_CH3);
    @(negedge clk);
    check("kc3 clr end", clr_flags, 6'h00);

    // ---- Write 0x2D on the edge that issues channel 5's end ----
    do_reset();
    wr(8'h25, 8'h77);
    wr(8'h2D, 8'h12);
    cen = 1'b1;
    for (int i = 1; i <= 4; i++) tick_expect("ch5", 3'(i), S_NONE, 16'h0);
    cpu_wr   = 1'b1;
    cpu_addr = 8'h2D;
    cpu_din  = 8'h99;
    tick_expect("ch5 race", 3'd5, S_END, 16'h1277);
    cpu_wr = 1'b0;
    check("ch5 still pending", pending, 6'h20);
    for (int i = 6; i <= 12; i++)
      tick_expect("ch5 reissue", 3'(i % 6), (i == 11) ? S_END : S_NONE,
                  (i == 11) ? 16'h9977 : 16'h0);
    check("ch5 pending done", pending, 6'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
